// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial frame link (serializer and receiver).
// State encodings and line levels live here so both ends agree on framing.
package serial_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } link_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input entering the clk
// domain. Both flops reset to 1 so an idle-high line reads as idle in reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next values: plain two-stage shift.
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    // Synchronizer flops, asynchronously preset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: recovers DATA_W-bit words from an LSB-first,
// start/stop framed line oversampled CLKS_PER_BIT times, sampled mid-bit.
// Optional macro SERIAL_RX_PARITY_EN adds an even-parity bit and the
// parity_err_out port.
// Output strobes: valid_out is a 1-cycle pulse with data_out updated in the
// same cycle; there is no backpressure, the consumer must take it then.
// frame_err_out is a 1-cycle pulse and never coincides with valid_out.
module serial_frame_rx
    import serial_link_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              d_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              frame_err_out,
    output logic              busy_out
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic              parity_err_out
`endif
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic d_sync;

    link_state_e       state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [BIT_W-1:0]  bit_d, bit_q;
    logic [DATA_W-1:0] shift_d, shift_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;
    logic              ferr_d, ferr_q;
`ifdef SERIAL_RX_PARITY_EN
    logic              par_bit_d, par_bit_q;
    logic              perr_d, perr_q;
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (reset_in),
        .d_in  (d_in),
        .q_out (d_sync)
    );

    // Next-state, counters, shifter and output strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (d_sync == START_LEVEL) state_d = ST_START;
            end
            ST_START: begin
                // Half a bit in: confirm the start bit, otherwise it was a glitch.
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = (d_sync == START_LEVEL) ? ST_DATA : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    // LSB arrives first, so after DATA_W shifts it sits at bit 0.
                    shift_d = (shift_q >> 1) | (DATA_W'(d_sync) << (DATA_W - 1));
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = '0;
                    par_bit_d = d_sync;
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (d_sync == STOP_LEVEL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                        perr_d  = (^shift_q) ^ par_bit_q;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign frame_err_out = ferr_q;
    assign busy_out      = (state_q != ST_IDLE);
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err_out = perr_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (DATA_W=8, CLKS_PER_BIT=4).
module tb_serial_frame_rx;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
`ifdef SERIAL_RX_PARITY_EN
    localparam int LAT      = 44;  // start edge -> valid edge
    localparam int FRAME_CY = 44;  // 11 bits x 4 clocks
`else
    localparam int LAT      = 40;
    localparam int FRAME_CY = 40;  // 10 bits x 4 clocks
`endif
    localparam int BUSY_CY = LAT - 2;

    logic              clk = 1'b0;
    logic              reset_in;
    logic              d_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              frame_err_out;
    logic              busy_out;
`ifdef SERIAL_RX_PARITY_EN
    logic              parity_err_out;
`endif

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int busy_cnt = 0;
    int overlap = 0;
    int v_cyc_q[$];
    logic [DATA_W-1:0] v_data_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int f_cyc_q[$];
    int p_cyc_q[$];

    int k0, k1, b0;

    serial_frame_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .d_in          (d_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .frame_err_out (frame_err_out),
        .busy_out      (busy_out)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .parity_err_out(parity_err_out)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Monitor: sampled 1 time unit after each rising edge; cyc = edge index.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (valid_out) begin
            v_cyc_q.push_back(cyc);
            v_data_q.push_back(data_out);
        end
        if (frame_err_out) f_cyc_q.push_back(cyc);
        if (valid_out && frame_err_out) overlap++;
        if (busy_out) busy_cnt++;
`ifdef SERIAL_RX_PARITY_EN
        if (parity_err_out) p_cyc_q.push_back(cyc);
`endif
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        d_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Drives one frame starting at a negedge; returns the index of the first
    // rising edge that sees the start bit.
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par,
                              input logic stop, output int k);
        k = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) send_bit(data[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bz) d_in = 1'b0;
`endif
        send_bit(stop);
        d_in = 1'b1;
    endtask

    task automatic idle(input int n);
        d_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        v_cyc_q.delete();
        v_data_q.delete();
        exp_q.delete();
        f_cyc_q.delete();
        p_cyc_q.delete();
    endtask

    initial begin
        // Reset
        reset_in = 1'b0;
        d_in     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_ferr", 32'(frame_err_out), 32'h0);
        check("rst_busy", 32'(busy_out), 32'h0);
        reset_in = 1'b1;
        idle(6);

        // Single frame 0xA5
        clear_logs();
        b0 = busy_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, ^8'hA5, 1'b1, k0);
        idle(20);
        check("a5_count", 32'(v_cyc_q.size()), 32'd1);
        check("a5_data", 32'(v_data_q[0]), 32'(exp_q[0]));
        check("a5_latency", 32'(v_cyc_q[0] - k0), 32'(LAT));
        check("a5_ferr", 32'(f_cyc_q.size()), 32'd0);
        check("a5_busy", 32'(busy_cnt - b0), 32'(BUSY_CY));
        check("a5_data_out", 32'(data_out), 32'hA5);

        // Back-to-back 0x3C then 0xC3
        clear_logs();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, ^8'h3C, 1'b1, k0);
        send_frame(8'hC3, ^8'hC3, 1'b1, k1);
        idle(20);
        check("b2b_count", 32'(v_cyc_q.size()), 32'd2);
        check("b2b_data0", 32'(v_data_q[0]), 32'(exp_q[0]));
        check("b2b_data1", 32'(v_data_q[1]), 32'(exp_q[1]));
        check("b2b_spacing", 32'(v_cyc_q[1] - v_cyc_q[0]), 32'(FRAME_CY));
        check("b2b_lat2", 32'(v_cyc_q[1] - k1), 32'(LAT));

        // Frame error: 0x5A with stop bit 0
        clear_logs();
        send_frame(8'h5A, ^8'h5A, 1'b0, k0);
        idle(20);
        check("ferr_count", 32'(f_cyc_q.size()), 32'd1);
        check("ferr_latency", 32'(f_cyc_q[0] - k0), 32'(LAT));
        check("ferr_valid", 32'(v_cyc_q.size()), 32'd0);
        check("ferr_data_kept", 32'(data_out), 32'hC3);

        // One-cycle glitch
        clear_logs();
        b0 = busy_cnt;
        d_in = 1'b0;
        @(negedge clk);
        idle(12);
        check("glitch_busy", 32'(busy_cnt - b0), 32'd2);
        check("glitch_valid", 32'(v_cyc_q.size()), 32'd0);
        check("glitch_ferr", 32'(f_cyc_q.size()), 32'd0);

        // Reset during data bit 4 of 0xFF
        clear_logs();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        d_in = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy_before", 32'(busy_out), 32'h1);
        #2;
        reset_in = 1'b0;
        #1;
        check("midrst_data", 32'(data_out), 32'h0);
        check("midrst_valid", 32'(valid_out), 32'h0);
        check("midrst_ferr", 32'(frame_err_out), 32'h0);
        check("midrst_busy", 32'(busy_out), 32'h0);
        repeat (3) @(negedge clk);
        reset_in = 1'b1;
        idle(20);
        check("midrst_no_valid", 32'(v_cyc_q.size()), 32'd0);
        check("midrst_no_ferr", 32'(f_cyc_q.size()), 32'd0);

        // Frame after reset: 0x81
        clear_logs();
        exp_q.push_back(8'h81);
        send_frame(8'h81, ^8'h81, 1'b1, k0);
        idle(20);
        check("x81_count", 32'(v_cyc_q.size()), 32'd1);
        check("x81_data", 32'(v_data_q[0]), 32'(exp_q[0]));
        check("x81_latency", 32'(v_cyc_q[0] - k0), 32'(LAT));

`ifdef SERIAL_RX_PARITY_EN
        // Wrong parity on 0x07 (correct even parity would be 1)
        clear_logs();
        send_frame(8'h07, 1'b0, 1'b1, k0);
        idle(20);
        check("par_valid_count", 32'(v_cyc_q.size()), 32'd1);
        check("par_err_count", 32'(p_cyc_q.size()), 32'd1);
        check("par_together", 32'(p_cyc_q[0]), 32'(v_cyc_q[0]));
        check("par_data", 32'(v_data_q[0]), 32'h07);
        check("par_latency", 32'(v_cyc_q[0] - k0), 32'd44);
`endif

        check("valid_ferr_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
